// File: rtl/dot_product_acc_16.sv
// Sequential dot-product engine: registered operands feed multiplier_16, and the
// registered 32-bit products are summed into an ACC_W-bit accumulator with a sticky overflow flag.

module multiplier_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);
  assign product = a * b;
endmodule

module dot_product_acc_16 #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      A,
  input  logic [15:0]      B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      op_a, op_b;
  logic             op_valid;
  logic [31:0]      mul_p, prod;
  logic             prod_valid;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             accept;

  multiplier_16 u_mul (
    .a       (op_a),
    .b       (op_b),
    .product (mul_p)
  );

  assign accept   = in_valid && (state == RUN);
  assign sum      = {1'b0, acc} + (ACC_W + 1)'(prod);
  assign result   = acc;
  assign overflow = ovf;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LEN_W'(1)) state_nxt = DRAIN;
      end
      // Once the operand stage is empty, the product still in flight is
      // absorbed by the accumulator on this same edge, so DONE sees the full sum.
      DRAIN: begin
        if (!op_valid) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_valid   <= 1'b0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_valid   <= accept;
      prod_valid <= op_valid;
      if (accept) begin
        op_a <= A;
        op_b <= B;
      end
      if (op_valid) prod <= mul_p;
      if (state == IDLE && start) begin
        cnt <= len;
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        if (accept) cnt <= cnt - LEN_W'(1);
        if (prod_valid) begin
          acc <= sum[ACC_W-1:0];
          ovf <= ovf | sum[ACC_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_acc_16.sv
// Directed self-checking bench for dot_product_acc_16; a 40-bit and a 32-bit
// instance share all inputs so wrap/overflow behaviour is checked alongside.

module tb_dot_product_acc_16;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [15:0] A, B;
  logic        in_ready, out_valid, overflow, busy;
  logic [39:0] result;
  logic        in_ready32, out_valid32, overflow32, busy32;
  logic [31:0] result32;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  dot_product_acc_16 #(.ACC_W(40), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .busy(busy)
  );

  dot_product_acc_16 #(.ACC_W(32), .LEN_W(8)) dut32 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready32), .A(A), .B(B),
    .out_valid(out_valid32), .out_ready(out_ready),
    .result(result32), .overflow(overflow32), .busy(busy32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    A = a;
    B = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
    tick();
  endtask

  // Wait for out_valid, check latency/result on both instances, hold, then handshake.
  task automatic collect(input string tag, input logic [63:0] exp, input int exp_lat,
                         input int hold);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (!out_valid && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), exp);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_res32"}, 64'(result32), {32'd0, exp[31:0]});
    check({tag, "_ovf32"}, 64'(overflow32), 64'(|exp[63:32]));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, {23'd0, out_valid, result}, {23'd1, exp[39:0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {62'd0, busy, out_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    out_ready = 1'b0; A = '0; B = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_outs", {59'd0, in_ready, out_valid, overflow, busy, |result}, 64'd0);

    do_start(8'd3);
    check("start_in_ready", 64'(in_ready), 64'd1);
    send(16'd5, 16'd3);
    send(16'd52, 16'd31);
    send(16'd121, 16'd255);
    collect("len3", 64'd32482, 2, 0);

    do_start(8'd1);
    send(16'd51733, 16'd13978);
    collect("len1", 64'd723123874, 2, 0);

    do_start(8'd0);
    check("len0_out_valid", 64'(out_valid), 64'd1);
    collect("len0", 64'd0, 0, 0);

    do_start(8'd255);
    for (int i = 0; i < 255; i++) send(16'hFFFF, 16'hFFFF);
    collect("len255", 64'd1095183237375, 2, 0);

    do_start(8'd2);
    send(16'hFFFF, 16'hFFFF);
    send(16'hFFFF, 16'hFFFF);
    collect("len2max", 64'd8589672450, 2, 0);

    do_start(8'd4);
    for (int k = 1; k <= 4; k++) begin
      send(16'(k), 16'(k));
      in_valid = 1'b0;
      for (int g = 0; g < (k % 3) + 1; g++) begin
        start = (g == 0);
        len   = '0;
        tick();
      end
      start = 1'b0;
      if (k < 4) check("bp_still_run", {62'd0, busy, in_ready}, 64'd3);
    end
    collect("bp", 64'd30, 0, 5);

    do_start(8'd4);
    send(16'd100, 16'd100);
    send(16'd200, 16'd200);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outs", {59'd0, in_ready, out_valid, overflow, busy, |result}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_out", 64'(out_valid), 64'd0);
    end
    do_start(8'd1);
    send(16'd7, 16'd9);
    collect("post_abort", 64'd63, 2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
